// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and helpers for the FIFO write-port arbiter.
// Revision    : 1.0
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Index width for a requester count; never below one bit.
    function automatic int gw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int next_ptr(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Rotating-priority picker; first set request at or above start.
// Revision    : 1.0
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   start,
    output logic            any,
    output logic [GW-1:0]   idx
);

    int pos;

    // Scan offsets high to low so the smallest offset from start is written last.
    always_comb begin
        pos = 0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = (int'(start) + k) % NREQ;
            if (req[pos]) begin
                idx = GW'(pos);
            end
        end
        any = |req;
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arb
// Description : Round-robin burst arbiter sharing the FIFO write port.
// Revision    : 1.0
// ============================================================================
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    parameter int CNTW  = 16
) (
    input  logic                     wclk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     full,
    output logic                     winc,
    output logic [DW-1:0]            wdata,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     busy,
    output logic [NREQ*CNTW-1:0]     beat_cnt
);

    localparam int GW = gw_of(NREQ);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [GW-1:0]   r_rr_ptr;
    logic [BW-1:0]   r_burst_cnt;
    logic            w_pick_any;
    logic [GW-1:0]   w_pick_idx;
    logic            w_sel_valid;
    logic            w_beat;
    logic            w_rel;
    logic [CNTW-1:0] r_cnt [NREQ];

    rr_pick #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_pick (
        .req   (req_valid),
        .start (r_rr_ptr),
        .any   (w_pick_any),
        .idx   (w_pick_idx)
    );

    assign w_sel_valid = req_valid[gnt_id];
    assign wdata       = req_data[gnt_id*DW +: DW];

    // full gates the write in the same cycle; relies on full being registered upstream.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        winc        = 1'b0;
        w_beat      = 1'b0;
        w_rel       = 1'b0;
        busy        = (r_state == GRANT);
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                req_ready[gnt_id] = ~full;
                winc              = w_sel_valid & ~full;
                w_beat            = winc;
                w_rel             = (w_beat && (r_burst_cnt == LAST_BEAT)) || !w_sel_valid;
                if (w_rel) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            gnt_id      <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) && w_pick_any) begin
                gnt_id      <= w_pick_idx;
                r_burst_cnt <= '0;
            end
            if (w_beat) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            if (w_rel) begin
                r_rr_ptr <= GW'(next_ptr(int'(gnt_id), NREQ));
            end
        end
    end

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_cnt
            // Saturating: a debug counter that wraps would misreport activity.
            always_ff @(posedge wclk) begin
                if (!rst_n) begin
                    r_cnt[i] <= '0;
                end else if (w_beat && (gnt_id == GW'(i)) && (r_cnt[i] != {CNTW{1'b1}})) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            assign beat_cnt[i*CNTW +: CNTW] = r_cnt[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arb
// Description : Self-checking bench for fifo_wr_arb (vector table + sequences).
// Revision    : 1.0
// ============================================================================
module tb_fifo_wr_arb;

    logic        wclk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        full;
    logic [3:0]  req_ready, req_ready_s;
    logic        winc, winc_s;
    logic [7:0]  wdata, wdata_s;
    logic [1:0]  gnt_id, gnt_id_s;
    logic        busy, busy_s;
    logic [63:0] beat_cnt;
    logic [15:0] beat_cnt_s;

    always #5 wclk = ~wclk;

    fifo_wr_arb #(.NREQ(4), .DW(8), .BURST(4), .CNTW(16)) dut (
        .wclk(wclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .full(full), .winc(winc), .wdata(wdata),
        .gnt_id(gnt_id), .busy(busy), .beat_cnt(beat_cnt)
    );

    fifo_wr_arb #(.NREQ(4), .DW(8), .BURST(4), .CNTW(4)) dut_sat (
        .wclk(wclk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready_s), .full(full), .winc(winc_s), .wdata(wdata_s),
        .gnt_id(gnt_id_s), .busy(busy_s), .beat_cnt(beat_cnt_s)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] valid;
        logic       full;
        logic       winc;
        logic [3:0] ready;
        logic       busy;
        logic [1:0] gnt;
        logic [7:0] wdata;
    } vec_t;

    vec_t vq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic f, input logic w,
                       input logic [3:0] rdy, input logic b, input logic [1:0] g,
                       input logic [7:0] d);
        vec_t e;
        e.rst_n = r; e.valid = v; e.full = f; e.winc = w;
        e.ready = rdy; e.busy = b; e.gnt = g; e.wdata = d;
        vq.push_back(e);
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic cyc(input string name, input logic [3:0] v, input logic f,
                       input logic w, input logic [3:0] rdy, input logic [7:0] d,
                       input logic b);
        req_valid = v;
        full      = f;
        @(negedge wclk);
        check({name, ".winc"},  {31'd0, winc}, {31'd0, w});
        check({name, ".ready"}, {28'd0, req_ready}, {28'd0, rdy});
        check({name, ".wdata"}, {24'd0, wdata}, {24'd0, d});
        check({name, ".busy"},  {31'd0, busy}, {31'd0, b});
        tick();
    endtask

    function automatic logic [15:0] cnt(input int i);
        return beat_cnt[i*16 +: 16];
    endfunction

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'h0;
        full      = 1'b0;
        req_data  = {8'h40, 8'h30, 8'h20, 8'h10};
        tick();

        // reset held, then release; all valids high
        add(0, 4'hF, 0, 0, 4'h0, 0, 0, 8'h10);
        add(0, 4'hF, 0, 0, 4'h0, 0, 0, 8'h10);
        add(1, 4'hF, 0, 0, 4'h0, 0, 0, 8'h10);
        // round-robin: 4 beats each, one bubble between grants
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 4; b++)
                add(1, 4'hF, 0, 1, 4'(1 << r), 1, 2'(r), 8'(8'h10 * (r + 1)));
            add(1, 4'hF, 0, 0, 4'h0, 0, 2'(r), 8'(8'h10 * (r + 1)));
        end
        // req0 drops valid at grant: forfeits immediately
        add(1, 4'h6, 0, 0, 4'h1, 1, 0, 8'h10);
        add(1, 4'h6, 0, 0, 4'h0, 0, 0, 8'h10);
        // req1: two beats then drops valid
        add(1, 4'h6, 0, 1, 4'h2, 1, 1, 8'h20);
        add(1, 4'h6, 0, 1, 4'h2, 1, 1, 8'h20);
        add(1, 4'h4, 0, 0, 4'h2, 1, 1, 8'h20);
        // rr_ptr now 2: req2 wins over req0
        add(1, 4'h5, 0, 0, 4'h0, 0, 1, 8'h20);
        add(1, 4'h5, 0, 1, 4'h4, 1, 2, 8'h30);
        add(1, 4'h0, 0, 0, 4'h4, 1, 2, 8'h30);
        add(1, 4'h0, 0, 0, 4'h0, 0, 2, 8'h30);

        for (int i = 0; i < vq.size(); i++) begin
            rst_n     = vq[i].rst_n;
            req_valid = vq[i].valid;
            full      = vq[i].full;
            @(negedge wclk);
            if (winc !== vq[i].winc || req_ready !== vq[i].ready || busy !== vq[i].busy ||
                gnt_id !== vq[i].gnt || wdata !== vq[i].wdata) begin
                n_fail++;
                $display("FAIL vec%0d: got winc=%b ready=%b busy=%b gnt=%0d wdata=%h expected winc=%b ready=%b busy=%b gnt=%0d wdata=%h",
                         i, winc, req_ready, busy, gnt_id, wdata,
                         vq[i].winc, vq[i].ready, vq[i].busy, vq[i].gnt, vq[i].wdata);
            end
            n_tests++;
            if (i == 1) begin
                check("reset.beat_cnt", beat_cnt[31:0], 32'd0);
            end
            tick();
            if (i == 21) begin
                for (int k = 0; k < 4; k++)
                    check($sformatf("rr.beat_cnt%0d", k), {16'd0, cnt(k)}, 32'd4);
            end
        end
        check("early.beat_cnt0", {16'd0, cnt(0)}, 32'd4);
        check("early.beat_cnt1", {16'd0, cnt(1)}, 32'd6);
        check("early.beat_cnt2", {16'd0, cnt(2)}, 32'd5);

        // backpressure mid-burst of req3
        req_data[31:24] = 8'h31;
        cyc("bp.arb",   4'h8, 0, 0, 4'h0, 8'h30, 0);
        cyc("bp.beat1", 4'h8, 0, 1, 4'h8, 8'h31, 1);
        req_data[31:24] = 8'h32;
        cyc("bp.beat2", 4'h8, 0, 1, 4'h8, 8'h32, 1);
        req_data[31:24] = 8'h33;
        for (int s = 0; s < 5; s++)
            cyc($sformatf("bp.stall%0d", s), 4'h8, 1, 0, 4'h0, 8'h33, 1);
        cyc("bp.beat3", 4'h8, 0, 1, 4'h8, 8'h33, 1);
        req_data[31:24] = 8'h34;
        cyc("bp.beat4", 4'h8, 0, 1, 4'h8, 8'h34, 1);
        cyc("bp.done",  4'h0, 0, 0, 4'h0, 8'h34, 0);
        check("bp.beat_cnt3", {16'd0, cnt(3)}, 32'd8);

        // reset mid-burst of req1
        cyc("mr.arb",   4'h2, 0, 0, 4'h0, 8'h34, 0);
        cyc("mr.beat1", 4'h2, 0, 1, 4'h2, 8'h20, 1);
        cyc("mr.beat2", 4'h2, 0, 1, 4'h2, 8'h20, 1);
        rst_n = 1'b0;
        cyc("mr.rst_cycle", 4'hF, 0, 1, 4'h2, 8'h20, 1);
        cyc("mr.after_rst", 4'hF, 0, 0, 4'h0, 8'h10, 0);
        check("mr.beat_cnt", beat_cnt[31:0] | beat_cnt[63:32], 32'd0);
        rst_n = 1'b1;
        cyc("mr.rearb", 4'hF, 0, 0, 4'h0, 8'h10, 0);
        @(negedge wclk);
        check("mr.gnt_id", {30'd0, gnt_id}, 32'd0);
        check("mr.winc",   {31'd0, winc}, 32'd1);

        // saturation: 20 beats from req2 only
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'h4;
        for (int c = 0; c < 25; c++) tick();
        req_valid = 4'h0;
        tick();
        check("sat.cnt16", {16'd0, cnt(2)}, 32'd20);
        check("sat.cnt4",  {28'd0, beat_cnt_s[11:8]}, 32'd15);
        check("sat.other", {28'd0, beat_cnt_s[3:0]}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
